// File: rtl/mini_src_pkg.sv
// Shared Mini SRC datapath types: word width, divider FSM states, divider result record.
package mini_src_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] quotient;
    logic [WORD_W-1:0] remainder;
    logic              dbz;
  } div_result_t;

endpackage

// File: rtl/seq_divider_if.sv
// Divider request/response bundle: the control unit is the master, the divider the slave.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/twos_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = en ? ('0 - a) : a;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider feeding HI (remainder) / LO (quotient).
// Optional signed support is built only when DIV_SIGNED_EN is defined; otherwise
// signed_op is ignored and every divide is unsigned with identical latency.
module seq_divider
  import mini_src_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic         clock,
  input  logic         clear,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic             accept, zero_div;

  assign accept   = (state == IDLE) && bus.start;
  assign zero_div = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
  logic s_a, s_b, q_neg, r_neg;

  assign s_a = bus.signed_op & bus.dividend[WIDTH-1];
  assign s_b = bus.signed_op & bus.divisor[WIDTH-1];

  twos_negate #(.WIDTH(WIDTH)) u_mag_a (.en(s_a),   .a(bus.dividend), .y(a_mag));
  twos_negate #(.WIDTH(WIDTH)) u_mag_b (.en(s_b),   .a(bus.divisor),  .y(b_mag));
  twos_negate #(.WIDTH(WIDTH)) u_fix_q (.en(q_neg), .a(quo_q),        .y(q_fix));
  twos_negate #(.WIDTH(WIDTH)) u_fix_r (.en(r_neg), .a(rem_q),        .y(r_fix));

  // Result signs captured at accept: quotient negative on sign mismatch, remainder follows dividend.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= s_a ^ s_b;
      r_neg <= s_a;
    end
  end
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fix = quo_q;
  assign r_fix = rem_q;
`endif

  // Trial subtract of the shifted partial remainder; rem < div keeps the result in WIDTH+1 signed range.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: zero divisor short-circuits straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = zero_div ? DONE : ITER;
      ITER:    if (count == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, one restoring step per ITER cycle, result registration in FIX.
  always_ff @(posedge clock) begin
    if (clear) begin
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          count <= '0;
          rem_q <= '0;
          quo_q <= a_mag;
          div_q <= b_mag;
          dbz_q <= zero_div;
          if (zero_div) begin
            quotient_q  <= '1;
            remainder_q <= bus.dividend;
          end
        end
        ITER: begin
          count <= count + 1'b1;
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
